// File: rtl/step0_bfly_tx_if.sv
// step0_bfly_tx_if: 16-lane complex input words in, registered butterfly add/sub words out.
interface step0_bfly_tx_if;
  logic din_valid;
  logic din_sof;
  logic signed [11:0] din_r [0:15];
  logic signed [11:0] din_i [0:15];
  logic dout_valid;
  logic dout_last;
  logic ovf;
  logic signed [11:0] dout_add_r [0:15];
  logic signed [11:0] dout_add_i [0:15];
  logic signed [11:0] dout_sub_r [0:15];
  logic signed [11:0] dout_sub_i [0:15];
  modport master (
    output din_valid, din_sof, din_r, din_i,
    input  dout_valid, dout_last, ovf, dout_add_r, dout_add_i, dout_sub_r, dout_sub_i
  );
  modport slave (
    input  din_valid, din_sof, din_r, din_i,
    output dout_valid, dout_last, ovf, dout_add_r, dout_add_i, dout_sub_r, dout_sub_i
  );
endinterface

// File: rtl/step0_bfly_tx.sv
// step0_bfly_tx: first radix-2 stage of a 512-point frame; STEP0_BFLY_TX_SCALE_EN halves results instead of saturating.
module step0_bfly_tx (
  input logic clk,
  input logic rst,
  step0_bfly_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  state_t r_state;
  logic [4:0] r_cnt;
  logic signed [11:0] r_buf_r [0:15][0:15];
  logic signed [11:0] r_buf_i [0:15][0:15];
  logic r_valid, r_last, r_ovf;
  logic signed [11:0] r_add_r [0:15], r_add_i [0:15], r_sub_r [0:15], r_sub_i [0:15];
  logic signed [11:0] w_add_r [0:15], w_add_i [0:15], w_sub_r [0:15], w_sub_i [0:15];
  logic [15:0] w_clip;
  logic [3:0] w_j, w_wa;
  logic w_sof, w_emit, w_wr;
  function automatic logic signed [11:0] fin(input logic signed [12:0] s);
`ifdef STEP0_BFLY_TX_SCALE_EN
    return s[12:1];
`else
    return (s[12] ^ s[11]) ? {s[12], {11{~s[12]}}} : s[11:0];
`endif
  endfunction
  function automatic logic clip(input logic signed [12:0] s);
`ifdef STEP0_BFLY_TX_SCALE_EN
    return 1'b0;
`else
    return s[12] ^ s[11];
`endif
  endfunction
  // a din_sof word always restarts the frame, so it never produces an output
  assign w_sof  = bus.din_valid & bus.din_sof;
  assign w_emit = bus.din_valid & ~bus.din_sof & (r_state == EMIT);
  assign w_wr   = w_sof | (bus.din_valid & (r_state == FILL));
  assign w_wa   = w_sof ? 4'd0 : r_cnt[3:0];
  assign w_j    = r_cnt[3:0];
  for (genvar g = 0; g < 16; g++) begin : g_lane
    logic signed [12:0] w_sar, w_sai, w_ssr, w_ssi;
    assign w_sar = 13'(r_buf_r[w_j][g]) + 13'(bus.din_r[g]);
    assign w_sai = 13'(r_buf_i[w_j][g]) + 13'(bus.din_i[g]);
    assign w_ssr = 13'(r_buf_r[w_j][g]) - 13'(bus.din_r[g]);
    assign w_ssi = 13'(r_buf_i[w_j][g]) - 13'(bus.din_i[g]);
    assign w_add_r[g] = fin(w_sar);
    assign w_add_i[g] = fin(w_sai);
    assign w_sub_r[g] = fin(w_ssr);
    assign w_sub_i[g] = fin(w_ssi);
    assign w_clip[g] = clip(w_sar) | clip(w_sai) | clip(w_ssr) | clip(w_ssi);
  end
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf_r[w_wa] <= bus.din_r;
      r_buf_i[w_wa] <= bus.din_i;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= 5'd0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_ovf <= 1'b0;
      r_add_r <= '{default: '0};
      r_add_i <= '{default: '0};
      r_sub_r <= '{default: '0};
      r_sub_i <= '{default: '0};
    end else begin
      r_valid <= w_emit;
      r_last <= w_emit & (r_cnt == 5'd31);
      if (w_emit) begin
        r_add_r <= w_add_r;
        r_add_i <= w_add_i;
        r_sub_r <= w_sub_r;
        r_sub_i <= w_sub_i;
        r_ovf <= r_ovf | (|w_clip);
      end
      if (w_sof) begin
        r_state <= FILL;
        r_cnt <= 5'd1;
      end else if (bus.din_valid && r_state != IDLE) begin
        r_cnt <= r_cnt + 5'd1;
        r_state <= (r_cnt == 5'd15) ? EMIT : (r_cnt == 5'd31) ? IDLE : r_state;
      end
    end
  end
  assign bus.dout_valid = r_valid;
  assign bus.dout_last  = r_last;
  assign bus.ovf        = r_ovf;
  assign bus.dout_add_r = r_add_r;
  assign bus.dout_add_i = r_add_i;
  assign bus.dout_sub_r = r_sub_r;
  assign bus.dout_sub_i = r_sub_i;
endmodule

// File: tb/tb_step0_bfly_tx.sv
// tb_step0_bfly_tx: directed vector table plus hand sequences for saturation and mid-frame reset.
module tb_step0_bfly_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  step0_bfly_tx_if bus();
  step0_bfly_tx dut (.clk(clk), .rst(rst), .bus(bus));
  // r/i are lane-0 inputs; ar..si are raw 13-bit lane-0 results; lo adds +l / -l lane offsets
  typedef struct {
    bit v, sof, lo;
    int r, i;
    bit ev, el;
    int ar, ai, sr, si;
  } vec_t;
  vec_t tv[$];
  int tests = 0, fails = 0, vn = 0;
  int h_ar[16], h_ai[16], h_sr[16], h_si[16];
  bit ovf_m = 0;
  function automatic int fin(int s);
`ifdef STEP0_BFLY_TX_SCALE_EN
    return s >>> 1;
`else
    return s > 2047 ? 2047 : (s < -2048 ? -2048 : s);
`endif
  endfunction
  function automatic bit clips(int s);
`ifdef STEP0_BFLY_TX_SCALE_EN
    return 1'b0;
`else
    return s > 2047 || s < -2048;
`endif
  endfunction
  function automatic void push(bit v, bit sof, bit lo, int r, int i, bit ev, bit el, int ar, int ai, int sr, int si);
    vec_t t;
    t.v = v; t.sof = sof; t.lo = lo; t.r = r; t.i = i;
    t.ev = ev; t.el = el; t.ar = ar; t.ai = ai; t.sr = sr; t.si = si;
    tv.push_back(t);
  endfunction
  function automatic void fill(int br, int bi, int st, int n, bit gap, bit lo);
    for (int j = 0; j < n; j++) begin
      push(1, j == 0, lo, br + st * j, bi - st * j, 0, 0, 0, 0, 0, 0);
      if (gap) push(0, 0, lo, 777, -777, 0, 0, 0, 0, 0, 0);
    end
  endfunction
  function automatic void emit(int br, int bi, int dr, int di, int st, int n, bit gap, bit lo);
    for (int j = 0; j < n; j++) begin
      push(1, 0, lo, dr, di, 1, j == 15, br + st * j + dr, bi - st * j + di, br + st * j - dr, bi - st * j - di);
      if (gap) push(0, 0, lo, -777, 777, 0, 0, 0, 0, 0, 0);
    end
  endfunction
  task automatic check_out(input vec_t t);
    int bad_l;
    int got, want;
    tests++;
    if (bus.dout_valid !== t.ev) begin
      fails++;
      $display("FAIL valid vec %0d: got %b expected %b", vn, bus.dout_valid, t.ev);
    end
    tests++;
    if (bus.dout_last !== t.el) begin
      fails++;
      $display("FAIL last vec %0d: got %b expected %b", vn, bus.dout_last, t.el);
    end
    if (t.ev) begin
      for (int l = 0; l < 16; l++) begin
        int o;
        o = t.lo ? 2 * l : 0;
        h_ar[l] = fin(t.ar + o);
        h_ai[l] = fin(t.ai - o);
        h_sr[l] = fin(t.sr);
        h_si[l] = fin(t.si);
        if (clips(t.ar + o) || clips(t.ai - o) || clips(t.sr) || clips(t.si)) ovf_m = 1;
      end
    end
    bad_l = -1;
    got = 0;
    want = 0;
    for (int l = 0; l < 16; l++) begin
      if (bad_l < 0) begin
        if ($signed(bus.dout_add_r[l]) != h_ar[l]) begin bad_l = l; got = bus.dout_add_r[l]; want = h_ar[l]; end
        else if ($signed(bus.dout_add_i[l]) != h_ai[l]) begin bad_l = l; got = bus.dout_add_i[l]; want = h_ai[l]; end
        else if ($signed(bus.dout_sub_r[l]) != h_sr[l]) begin bad_l = l; got = bus.dout_sub_r[l]; want = h_sr[l]; end
        else if ($signed(bus.dout_sub_i[l]) != h_si[l]) begin bad_l = l; got = bus.dout_sub_i[l]; want = h_si[l]; end
      end
    end
    tests++;
    if (bad_l >= 0) begin
      fails++;
      $display("FAIL data vec %0d lane %0d: got %0d expected %0d", vn, bad_l, got, want);
    end
  endtask
  task automatic apply(input vec_t t);
    bus.din_valid = t.v;
    bus.din_sof = t.sof;
    for (int l = 0; l < 16; l++) begin
      bus.din_r[l] = 12'(t.r + (t.lo ? l : 0));
      bus.din_i[l] = 12'(t.i - (t.lo ? l : 0));
    end
    @(posedge clk);
    #1;
    check_out(t);
    vn++;
  endtask
  task automatic run_q();
    foreach (tv[k]) apply(tv[k]);
    tv.delete();
    bus.din_valid = 1'b0;
    bus.din_sof = 1'b0;
  endtask
  task automatic check_ovf(input string nm);
    tests++;
    if (bus.ovf !== ovf_m) begin
      fails++;
      $display("FAIL ovf %s: got %b expected %b", nm, bus.ovf, ovf_m);
    end
  endtask
  task automatic check_reset(input string nm);
    bit bad;
    bad = 0;
    for (int l = 0; l < 16; l++)
      if (bus.dout_add_r[l] !== 12'sd0 || bus.dout_add_i[l] !== 12'sd0 ||
          bus.dout_sub_r[l] !== 12'sd0 || bus.dout_sub_i[l] !== 12'sd0) bad = 1;
    tests++;
    if (bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 || bus.ovf !== 1'b0 || bad) begin
      fails++;
      $display("FAIL reset %s: got valid=%b last=%b ovf=%b data_nonzero=%b expected all 0",
               nm, bus.dout_valid, bus.dout_last, bus.ovf, bad);
    end
    for (int l = 0; l < 16; l++) begin h_ar[l] = 0; h_ai[l] = 0; h_sr[l] = 0; h_si[l] = 0; end
    ovf_m = 0;
  endtask
  initial begin
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.din_sof = 1'b0;
    for (int l = 0; l < 16; l++) begin bus.din_r[l] = '0; bus.din_i[l] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_reset("initial");
    rst = 1'b0;
    // basic frame: add=(120,-40), sub=(80,-60) on lane 0
    fill(100, -50, 0, 16, 0, 1);
    emit(100, -50, 20, 10, 0, 16, 0, 1);
    push(0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    push(1, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    push(1, 0, 1, 9, 9, 0, 0, 0, 0, 0, 0);
    // same frame with a bubble after every word, per-word buffer variation
    fill(100, -50, 3, 16, 1, 1);
    emit(100, -50, 20, 10, 3, 16, 1, 1);
    // back-to-back frames, no idle cycle
    fill(-300, 200, 7, 16, 0, 1);
    emit(-300, 200, -50, 60, 7, 16, 0, 1);
    fill(500, -400, -5, 16, 0, 1);
    emit(500, -400, 30, -20, -5, 16, 0, 1);
    // abort during fill, then full frame
    fill(1, 1, 1, 5, 0, 1);
    fill(-700, 650, 11, 16, 0, 1);
    emit(-700, 650, 13, -17, 11, 16, 0, 1);
    // abort at counter 20 (word carries din_sof), then full frame
    fill(40, 40, 1, 16, 0, 1);
    emit(40, 40, 5, 5, 1, 4, 0, 1);
    fill(333, -222, 2, 16, 0, 1);
    emit(333, -222, -111, 44, 2, 16, 0, 1);
    run_q();
    check_ovf("after normal frames");
    // positive saturation on add
    fill(2000, 0, 0, 16, 0, 0);
    emit(2000, 0, 1000, 0, 0, 16, 0, 0);
    run_q();
    tests++;
`ifdef STEP0_BFLY_TX_SCALE_EN
    if ($signed(bus.dout_add_r[0]) != 1500 || $signed(bus.dout_sub_r[0]) != 500 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL sat_const: got add_r=%0d sub_r=%0d ovf=%b expected 1500 500 0",
               $signed(bus.dout_add_r[0]), $signed(bus.dout_sub_r[0]), bus.ovf);
    end
`else
    if ($signed(bus.dout_add_r[0]) != 2047 || $signed(bus.dout_sub_r[0]) != 1000 || bus.ovf !== 1'b1) begin
      fails++;
      $display("FAIL sat_const: got add_r=%0d sub_r=%0d ovf=%b expected 2047 1000 1",
               $signed(bus.dout_add_r[0]), $signed(bus.dout_sub_r[0]), bus.ovf);
    end
`endif
    // negative saturation on sub
    fill(-2000, -2000, 0, 16, 0, 0);
    emit(-2000, -2000, 1000, 1000, 0, 16, 0, 0);
    run_q();
    check_ovf("after saturation");
    // reset asserted while the counter-25 word is presented
    fill(10, 10, 2, 16, 0, 1);
    emit(10, 10, 3, 3, 2, 9, 0, 1);
    run_q();
    bus.din_valid = 1'b1;
    bus.din_sof = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("mid-frame");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) push(1, 0, 1, 50 + k, -50 - k, 0, 0, 0, 0, 0, 0);
    fill(-1024, 1023, 4, 16, 0, 1);
    emit(-1024, 1023, 512, -511, 4, 16, 0, 1);
    run_q();
    check_ovf("after reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
